// File: rtl/s298_bist_pkg.sv
// s298_bist_pkg
// Shared definitions for the s298 BIST sequencer and its MISR:
//   - state_t        : sequencer states
//   - BIST_WIDTH     : LFSR / MISR width
//   - TAP_MASK       : feedback taps (bits 15, 13, 12, 10)
//   - DUT_RST_CYCLES : cycles the core is held in reset before stimulus
//   - shift_fb()     : one Fibonacci shift step using TAP_MASK
package s298_bist_pkg;

    localparam int BIST_WIDTH = 16;
    localparam logic [BIST_WIDTH-1:0] TAP_MASK = 16'hB400;
    localparam int DUT_RST_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        RST_DUT,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // Shift left by one and feed the XOR of the tapped bits into bit 0.
    function automatic logic [BIST_WIDTH-1:0] shift_fb(input logic [BIST_WIDTH-1:0] q);
        return {q[BIST_WIDTH-2:0], ^(q & TAP_MASK)};
    endfunction

endpackage

// File: rtl/s298_bist_misr.sv
// s298_bist_misr
// 16-bit multiple-input signature register for a 6-output benchmark core.
// Ports:
//   clk  in  1   : clock
//   rst  in  1   : synchronous active-high reset, clears the signature
//   clr  in  1   : synchronous clear (wins over en)
//   en   in  1   : compact din this cycle
//   din  in  6   : core outputs to compact into the low bits
//   sig  out 16  : current signature
module s298_bist_misr
    import s298_bist_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [5:0]            din,
    output logic [BIST_WIDTH-1:0] sig
);

    // Each enabled cycle shifts with feedback and folds the core outputs
    // into the low six bits.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= shift_fb(sig) ^ {{(BIST_WIDTH-6){1'b0}}, din};
        end
    end

endmodule

// File: rtl/s298_bist_ctrl.sv
// s298_bist_ctrl
// BIST sequencer for the s298 benchmark core. A start request resets the core
// for two cycles, drives G0/G1/G2 from a 16-bit LFSR for CYCLES cycles,
// compacts the six core outputs into a MISR (plus one flush cycle because
// the core outputs are registered) and then reports completion.
// Optional feature macro: S298_BIST_GOLDEN_EN adds the GOLDEN parameter and
// the pass output (final signature compared against GOLDEN).
// Ports:
//   clk        in  1  : clock
//   rst        in  1  : synchronous active-high reset
//   start      in  1  : run request, honoured in IDLE or DONE
//   busy       out 1  : high in RST_DUT, RUN, FLUSH
//   done       out 1  : high in DONE
//   signature  out 16 : MISR contents, final while done=1
//   dut_rst    out 1  : reset to the core
//   dut_g0/1/2 out 1  : core primary inputs
//   dut_out    in  6  : core outputs {G117,G132,G66,G118,G133,G67}
//   pass       out 1  : (S298_BIST_GOLDEN_EN only) signature matched GOLDEN
module s298_bist_ctrl
    import s298_bist_pkg::*;
#(
    parameter int unsigned           CYCLES    = 1024,
    parameter logic [BIST_WIDTH-1:0] LFSR_SEED = 16'hACE1
`ifdef S298_BIST_GOLDEN_EN
    ,
    parameter logic [BIST_WIDTH-1:0] GOLDEN    = 16'h0000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [BIST_WIDTH-1:0] signature,
    output logic                  dut_rst,
    output logic                  dut_g0,
    output logic                  dut_g1,
    output logic                  dut_g2,
    input  logic [5:0]            dut_out
`ifdef S298_BIST_GOLDEN_EN
    ,
    output logic                  pass
`endif
);

    state_t                  state;
    logic [15:0]             cnt;
    logic [BIST_WIDTH-1:0]   lfsr;
    logic                    launch;
    logic                    in_run;

    // A run is launched from IDLE or DONE only; start while busy is ignored.
    assign launch = start && (state == IDLE || state == DONE);
    assign in_run = (state == RUN);

    // G0 clears the core, so it is ANDed from three taps to fire about 1/8
    // of the time; all stimulus is held at 0 outside RUN.
    assign dut_g0 = in_run & lfsr[0] & lfsr[3] & lfsr[7];
    assign dut_g1 = in_run & lfsr[1];
    assign dut_g2 = in_run & lfsr[2];

    // Sequencer with registered busy/done/dut_rst so they change together
    // with the state. The counter times both the core reset and the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            dut_rst <= 1'b0;
            lfsr    <= LFSR_SEED;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= RST_DUT;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        dut_rst <= 1'b1;
                        lfsr    <= LFSR_SEED;
                        cnt     <= '0;
                    end
                end
                RST_DUT: begin
                    if (cnt == 16'(DUT_RST_CYCLES - 1)) begin
                        state   <= RUN;
                        dut_rst <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RUN: begin
                    lfsr <= shift_fb(lfsr);
                    cnt  <= cnt + 16'd1;
                    if (cnt == 16'(CYCLES - 1)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    dut_rst <= 1'b0;
                end
            endcase
        end
    end

    // The MISR is cleared at the launch edge and compacts on every RUN edge
    // plus the single FLUSH edge that catches the core's last registered output.
    s298_bist_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (launch),
        .en  (state == RUN || state == FLUSH),
        .din (dut_out),
        .sig (signature)
    );

`ifdef S298_BIST_GOLDEN_EN
    // The verdict is taken on the FLUSH edge from the signature the MISR is
    // about to hold, so pass becomes valid in the same cycle as done.
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            pass <= 1'b0;
        end else if (state == FLUSH) begin
            pass <= ((shift_fb(signature) ^ {{(BIST_WIDTH-6){1'b0}}, dut_out}) == GOLDEN);
        end
    end
`endif

endmodule
